// File: rtl/lcd_pkg.sv
// Shared command codes and controller states for the LCD window controller.
package lcd_pkg;

    localparam logic [2:0] CMD_REFLASH = 3'd0;
    localparam logic [2:0] CMD_LOAD    = 3'd1;
    localparam logic [2:0] CMD_RIGHT   = 3'd2;
    localparam logic [2:0] CMD_LEFT    = 3'd3;
    localparam logic [2:0] CMD_UP      = 3'd4;
    localparam logic [2:0] CMD_DOWN    = 3'd5;
    localparam logic [2:0] CMD_CENTRE  = 3'd6;
    localparam logic [2:0] CMD_MIRROR  = 3'd7;

    typedef enum logic [1:0] {IDLE, LOAD, MOVE, OUT} state_t;

endpackage

// File: rtl/lcd_img_ram.sv
// Image buffer: synchronous write, asynchronous read, storage not reset.
module lcd_img_ram #(
    parameter int DW    = 8,
    parameter int DEPTH = 36,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lcd_win_ctrl.sv
// LCD window controller: loads an IMG_H x IMG_W image, streams a WIN x WIN window.
// Optional horizontal mirror (cmd 7) enabled by defining LCD_MIRROR_EN.
module lcd_win_ctrl
    import lcd_pkg::*;
#(
    parameter int DW    = 8,
    parameter int IMG_W = 6,
    parameter int IMG_H = 6,
    parameter int WIN   = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] datain,
    input  logic [2:0]    cmd,
    input  logic          cmd_valid,
    output logic [DW-1:0] dataout,
    output logic          output_valid,
    output logic          busy
);

    localparam int N    = IMG_W * IMG_H;
    localparam int AW   = $clog2(N);
    localparam int XW   = $clog2(IMG_W);
    localparam int YW   = $clog2(IMG_H);
    localparam int WW   = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int XMAX = IMG_W - WIN;
    localparam int YMAX = IMG_H - WIN;
    localparam int CX   = (IMG_W - WIN + 1) / 2;
    localparam int CY   = (IMG_H - WIN + 1) / 2;

    state_t        state;
    logic [2:0]    op;
    logic [AW-1:0] lcnt;
    logic [XW-1:0] ox;
    logic [YW-1:0] oy;
    logic [WW-1:0] r, c, cc;
    logic          fin;
    logic          mirror;
    logic          we;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;

`ifndef LCD_MIRROR_EN
    assign mirror = 1'b0;
`endif

    assign we    = (state == LOAD);
    assign cc    = mirror ? (WW'(WIN - 1) - c) : c;
    assign raddr = AW'((int'(oy) + int'(r)) * IMG_W + int'(ox) + int'(cc));

    lcd_img_ram #(.DW(DW), .DEPTH(N), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (lcnt),
        .wdata (datain),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            op           <= CMD_REFLASH;
            lcnt         <= '0;
            ox           <= XW'(CX);
            oy           <= YW'(CY);
            r            <= '0;
            c            <= '0;
            fin          <= 1'b0;
            dataout      <= '0;
            output_valid <= 1'b0;
            busy         <= 1'b0;
`ifdef LCD_MIRROR_EN
            mirror       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    busy  <= 1'b1;
                    op    <= cmd;
                    lcnt  <= '0;
                    r     <= '0;
                    c     <= '0;
                    fin   <= 1'b0;
                    state <= (cmd == CMD_LOAD) ? LOAD : MOVE;
                end
                LOAD: begin
                    if (lcnt == AW'(N - 1)) begin
                        ox    <= XW'(CX);
                        oy    <= YW'(CY);
`ifdef LCD_MIRROR_EN
                        mirror <= 1'b0;
`endif
                        state <= OUT;
                    end else begin
                        lcnt <= lcnt + 1'b1;
                    end
                end
                MOVE: begin
                    // Moves saturate at the legal origin range but still emit a window.
                    case (op)
                        CMD_RIGHT:  if (ox != XW'(XMAX)) ox <= ox + 1'b1;
                        CMD_LEFT:   if (ox != '0)        ox <= ox - 1'b1;
                        CMD_UP:     if (oy != '0)        oy <= oy - 1'b1;
                        CMD_DOWN:   if (oy != YW'(YMAX)) oy <= oy + 1'b1;
                        CMD_CENTRE: begin
                            ox <= XW'(CX);
                            oy <= YW'(CY);
                        end
`ifdef LCD_MIRROR_EN
                        CMD_MIRROR: mirror <= ~mirror;
`endif
                        default: ;
                    endcase
                    state <= OUT;
                end
                OUT: begin
                    if (fin) begin
                        output_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        dataout      <= rdata;
                        output_valid <= 1'b1;
                        if (c == WW'(WIN - 1)) begin
                            c <= '0;
                            if (r == WW'(WIN - 1)) fin <= 1'b1;
                            else                   r   <= r + 1'b1;
                        end else begin
                            c <= c + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lcd_win_ctrl.md
# lcd_win_ctrl

Parametrised LCD window controller. It loads a serial image of IMG_H×IMG_W pixels into an internal buffer, then streams a WIN×WIN viewing window to the panel driver. Commands move the window, recentre it, or refresh it without moving. It replaces the fixed 6×6/3×3 controller in the display path, between the command sequencer and the LCD panel interface.

## Interface
- DW, 8: pixel width in bits
- IMG_W, 6: image width in pixels
- IMG_H, 6: image height in pixels
- WIN, 3: window edge length; requires WIN ≤ IMG_W and WIN ≤ IMG_H
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- datain  in  DW  serial pixel input, raster order, used during Load
- cmd  in  3  command code
- cmd_valid  in  1  command strobe
- dataout  out  DW  window pixel output, registered
- output_valid  out  1  dataout holds a valid window pixel
- busy  out  1  controller cannot accept a command

## Operation
- Command codes:
  - 0 Reflash: output the window, no move
  - 1 Load
  - 2 Right: ox+1
  - 3 Left: ox−1
  - 4 Up: oy−1
  - 5 Down: oy+1
  - 6 Centre: origin set to (CX,CY)
  - 7: see Configuration
- Origin (ox,oy) is the window's top-left corner. Ranges: 0..IMG_W−WIN and 0..IMG_H−WIN.
- CX = (IMG_W−WIN+1)/2 and CY = (IMG_H−WIN+1)/2, using integer division. Defaults give (2,2).
- Moves saturate at the range limits. A saturated move still produces a full window output.
- Command acceptance: a command is accepted on a rising edge where cmd_valid=1 and busy=0. cmd_valid while busy=1 is ignored and is not queued.
- States:
  - IDLE → LOAD on cmd 1.
  - IDLE → MOVE on any other code.
  - LOAD → OUT after IMG_W·IMG_H pixels.
  - MOVE → OUT after 1 cycle.
  - OUT → IDLE after WIN² pixels.
- Load: writes pixels 0..N−1 (N = IMG_W·IMG_H) to buffer address k. On completion the origin is set to (CX,CY).
- Window pixel (r,c): read address (oy+r)·IMG_W + ox + c. Output order is raster, r outer and c inner.
- Widths:
  - Address width is $clog2(IMG_W·IMG_H).
  - Origin widths are $clog2(IMG_W) and $clog2(IMG_H).
  - All address arithmetic is unsigned, with no overflow at legal origins.
- Buffer contents are undefined after reset until the first Load. Reflash before any Load outputs undefined data, but the handshake is still correct.

## Timing
- Reset values:
  - dataout=0, output_valid=0, busy=0
  - origin=(CX,CY), state IDLE
- Accept at edge E0; busy=1 after E0.
- Load: datain is sampled at edges E1..EN, with pixel 0 at E1. The first output is valid after E(N+1).
- Non-load commands: the origin is updated at E1. The first output is valid after E2.
- Output phase: output_valid=1 for exactly WIN² consecutive cycles with no gaps.
- busy and output_valid fall at the same edge after the last pixel. The earliest next accept is the following edge.
- Reset mid-operation (any state): all outputs go to reset values immediately. A partial load leaves buffer contents undefined.

## Configuration
- LCD_MIRROR_EN defined:
  - cmd 7 toggles the horizontal mirror flag, then outputs the window.
  - While the flag is set, each row is emitted with c descending (WIN−1..0).
  - The flag is cleared by reset and by Load.
- LCD_MIRROR_EN undefined: cmd 7 behaves exactly as Reflash and no flag register exists.

## Structure
- Package lcd_pkg holds:
  - command code constants (CMD_REFLASH..CMD_MIRROR)
  - the state enum (IDLE, LOAD, MOVE, OUT)
- Sub-module lcd_img_ram:
  - IMG_W·IMG_H × DW storage with one synchronous write port and one asynchronous read port
  - no reset on storage
- The top level holds the FSM, pixel/row/column counters, origin registers and address generation.

## Test plan
- Load pixels 0..35, with defaults → 9 outputs: 14,15,16,20,21,22,26,27,28; then busy falls.
- Right, then Right again → origin (3,2): outputs 15,16,17,21,22,23,27,28,29 both times (saturation).
- Up ×3 from (2,2) → final window 2,3,4,8,9,10,14,15,16. Centre then restores the 14,15,16… output.
- cmd_valid pulsed while busy=1 during the output phase → ignored; the next window output is unchanged.
- Reset asserted on load pixel 10 → busy=0 and output_valid=0 immediately. A fresh Load then produces correct output.
- With LCD_MIRROR_EN, after Load: cmd 7 → 16,15,14,22,21,20,28,27,26. A second cmd 7 restores normal order. Without the macro, cmd 7 gives the Reflash output.
